// File: rtl/pkt_tx_pkg.sv
// Shared state encoding, limits and byte helpers for the pkt_tx packet transmitter.
package pkt_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    CHECK   = 3'd5
  } state_t;

  localparam int         MAX_LEN      = 32'd63;
  localparam logic [1:0] INVALID_ADDR = 2'b11;
  localparam int         CHECK_CYCLES = 32'd3;
  localparam int         BUF_DEPTH    = MAX_LEN + 32'd1;

  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic [7:0] header_byte(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload store for pkt_tx: 64x8 register array, one write port, one asynchronous read port.
module pkt_tx_buf
  import pkt_tx_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_r [BUF_DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity to a router.
// Optional PKT_TX_ERR_INJECT_EN adds inject_err, which inverts the transmitted parity byte.
module pkt_tx
  import pkt_tx_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
`ifdef PKT_TX_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  output logic       cmd_ready,
  output logic       cmd_err,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] data_in,
  output logic       pkt_valid,
  input  logic       busy,
  input  logic       err,
  output logic       done,
  output logic       pkt_err
);

  localparam logic [1:0] CHECK_LAST = 2'(CHECK_CYCLES - 32'd1);

  state_t     state_r;
  logic [5:0] len_r;
  logic [1:0] addr_r;
  logic [5:0] cnt_r;
  logic [5:0] idx_r;
  logic [7:0] par_r;
  logic [1:0] chk_r;
  logic       inject_r;

  logic       buf_we_s;
  logic [5:0] buf_raddr_s;
  logic [7:0] buf_rdata_s;

  pkt_tx_buf u_buf (
    .clock (clock),
    .we    (buf_we_s),
    .waddr (cnt_r),
    .wdata (src_data),
    .raddr (buf_raddr_s),
    .rdata (buf_rdata_s)
  );

  // Buffer control: write while loading, read one byte ahead of the byte on data_in.
  always_comb begin
    buf_we_s    = 1'b0;
    buf_raddr_s = 6'd0;
    if ((state_r == LOAD) && src_ready) begin
      buf_we_s = src_valid;
    end else begin
      buf_we_s = 1'b0;
    end
    if (state_r == PAYLOAD) begin
      buf_raddr_s = idx_r + 6'd1;
    end else begin
      buf_raddr_s = 6'd0;
    end
  end

  // Transmit FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r   <= IDLE;
      len_r     <= 6'd0;
      addr_r    <= 2'd0;
      cnt_r     <= 6'd0;
      idx_r     <= 6'd0;
      par_r     <= 8'h00;
      chk_r     <= 2'd0;
      inject_r  <= 1'b0;
      data_in   <= 8'h00;
      pkt_valid <= 1'b0;
      src_ready <= 1'b0;
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      done      <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if ((cmd_addr != INVALID_ADDR) && (cmd_len != 6'd0)) begin
              len_r     <= cmd_len;
              addr_r    <= cmd_addr;
              cnt_r     <= 6'd0;
              pkt_err   <= 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
              inject_r  <= inject_err;
`else
              inject_r  <= 1'b0;
`endif
              src_ready <= 1'b1;
              cmd_ready <= 1'b0;
              state_r   <= LOAD;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (src_valid) begin
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == (len_r - 6'd1)) begin
              src_ready <= 1'b0;
              data_in   <= header_byte(len_r, addr_r);
              pkt_valid <= 1'b1;
              par_r     <= header_byte(len_r, addr_r);
              state_r   <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            idx_r   <= 6'd0;
            data_in <= buf_rdata_s;
            state_r <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            par_r <= parity_acc(par_r, data_in);
            // Stop the index at len-1 so it never wraps past the packet.
            if (idx_r == (len_r - 6'd1)) begin
              pkt_valid <= 1'b0;
              data_in   <= inject_r ? ~parity_acc(par_r, data_in) : parity_acc(par_r, data_in);
              state_r   <= PARITY;
            end else begin
              idx_r   <= idx_r + 6'd1;
              data_in <= buf_rdata_s;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            data_in <= 8'h00;
            chk_r   <= 2'd0;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (err) begin
            pkt_err <= 1'b1;
          end
          if (chk_r == CHECK_LAST) begin
            chk_r     <= 2'd0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            chk_r <= chk_r + 2'd1;
            done  <= (chk_r == (CHECK_LAST - 2'd1));
          end
        end
        default: begin
          data_in   <= 8'h00;
          pkt_valid <= 1'b0;
          src_ready <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: expected router bytes are queued at command time and popped per transfer.
module tb_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_ready;
  logic       cmd_err;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy;
  logic       err;
  logic       done;
  logic       pkt_err;
`ifdef PKT_TX_ERR_INJECT_EN
  logic       inject_err;
`endif

  always #5 clock = ~clock;

  pkt_tx dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef PKT_TX_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .cmd_ready (cmd_ready),
    .cmd_err   (cmd_err),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .data_in   (data_in),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .err       (err),
    .done      (done),
    .pkt_err   (pkt_err)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] pay [64];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic bad_cmd(input logic [1:0] a, input logic [5:0] l);
    @(negedge clock);
    start = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge clock);
    start = 1'b0;
    check("cmd_err_pulse", cmd_err, 1);
    check("cmd_ready_idle", cmd_ready, 1);
    check("src_ready_idle", src_ready, 0);
    @(negedge clock);
    check("cmd_err_clear", cmd_err, 0);
    check("src_ready_still_idle", src_ready, 0);
  endtask

  task automatic send_packet(input logic [1:0] addr, input logic [5:0] len, input bit fixed,
                             input bit gap, input int busy_item, input int busy_n,
                             input int err_cyc, input bit inj, input int abort_item,
                             input int exp_load, input bit start_in_load);
    logic [7:0] par;
    item_t      it;
    int         i, ld, popped, busy_left, cyc;
    bit         acc;

    par  = {len, addr};
    it.v = 1'b1; it.d = {len, addr};
    exp_q.push_back(it);
    for (int k = 0; k < int'(len); k++) begin
      pay[k] = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom_range(0, 255));
      par    = par ^ pay[k];
      it.v = 1'b1; it.d = pay[k];
      exp_q.push_back(it);
    end
    if (inj) par = ~par;
    it.v = 1'b0; it.d = par;
    exp_q.push_back(it);

    @(negedge clock);
    start = 1'b1; cmd_addr = addr; cmd_len = len;
`ifdef PKT_TX_ERR_INJECT_EN
    inject_err = inj;
`endif
    @(negedge clock);
    start = 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    check("cmd_ready_load", cmd_ready, 0);
    check("pkt_err_clear_on_start", pkt_err, 0);
    check("pkt_valid_load", pkt_valid, 0);

    i = 0; ld = 0;
    while (i < int'(len) && ld < 200) begin
      if (start_in_load) begin
        start = 1'b1; cmd_addr = 2'b11; cmd_len = 6'd4;
      end
      src_valid = gap ? (ld % 2 == 1) : 1'b1;
      src_data  = pay[i];
      check("src_ready_load", src_ready, 1);
      acc = src_valid && src_ready;
      ld++;
      @(negedge clock);
      if (acc) i++;
      check("cmd_err_not_idle", cmd_err, 0);
    end
    src_valid = 1'b0; start = 1'b0;
    check("load_done", i, int'(len));
    if (exp_load > 0) check("load_cycles", ld, exp_load);
    check("src_ready_after_load", src_ready, 0);

    popped = 0; busy_left = busy_n; cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      it = exp_q[0];
      check("data_in", data_in, it.d);
      check("pkt_valid", pkt_valid, it.v);
      if (popped == abort_item) begin
        resetn = 1'b0; busy = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_in", data_in, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_src_ready", src_ready, 0);
        exp_q.delete();
        return;
      end
      if (popped == busy_item && busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else begin
        busy = 1'b0;
      end
      if (!busy) begin
        void'(exp_q.pop_front());
        popped++;
      end
      @(negedge clock);
      cyc++;
    end
    busy = 1'b0;
    check("router_drained", exp_q.size(), 0);
    exp_q.delete();

    for (int k = 1; k <= 3; k++) begin
      err = (k == err_cyc);
      check("done_check_phase", done, (k == 3));
      check("cmd_ready_check_phase", cmd_ready, 0);
      check("data_in_check_phase", data_in, 0);
      check("pkt_err_check_phase", pkt_err, (err_cyc != 0) && (err_cyc < k));
      @(negedge clock);
    end
    err = 1'b0;
    check("done_cleared", done, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("pkt_err_final", pkt_err, err_cyc != 0);
  endtask

  initial begin
    bit inj;
    resetn = 1'b0; start = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
    src_data = 8'h00; src_valid = 1'b0; busy = 1'b0; err = 1'b0;
`ifdef PKT_TX_ERR_INJECT_EN
    inject_err = 1'b0;
    inj = 1'b1;
`else
    inj = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset_data_in", data_in, 0);
    check("reset_pkt_valid", pkt_valid, 0);
    check("reset_src_ready", src_ready, 0);
    check("reset_cmd_err", cmd_err, 0);
    check("reset_done", done, 0);
    check("reset_pkt_err", pkt_err, 0);
    resetn = 1'b1;
    @(negedge clock);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Basic packet 0D,11,22,33 then parity 0D
    send_packet(2'd1, 6'd3, 1'b1, 1'b0, -1, 0, 0, 1'b0, -1, 3, 1'b0);
    // Same packet with the router busy for two cycles on byte 22
    send_packet(2'd1, 6'd3, 1'b1, 1'b0, 2, 2, 0, 1'b0, -1, 3, 1'b0);
    // Rejected commands
    bad_cmd(2'b11, 6'd4);
    bad_cmd(2'b00, 6'd0);
    // Maximum packet with source gaps and a start held during LOAD
    send_packet(2'd2, 6'd63, 1'b0, 1'b1, 10, 3, 0, 1'b0, -1, 126, 1'b1);
    // Router error in CHECK cycle 2 (parity inverted when the inject option is built)
    send_packet(2'd0, 6'd4, 1'b0, 1'b0, 0, 1, 2, inj, -1, 4, 1'b0);
    repeat (4) @(negedge clock);
    check("pkt_err_sticky", pkt_err, 1);
    // Reset while payload byte 5 is on the router
    send_packet(2'd0, 6'd8, 1'b0, 1'b0, -1, 0, 0, 1'b0, 6, 8, 1'b0);
    // Recovery packet, busy held on the parity byte
    send_packet(2'd2, 6'd5, 1'b0, 1'b0, 6, 2, 3, 1'b0, -1, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: resetn  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  command request; cmd_addr  in  2  destination port; cmd_len  in  6  payload byte count.
REQ-004 SHALL have ports: cmd_ready  out  1  high only in IDLE; cmd_err  out  1  one-cycle pulse on rejected command.
REQ-005 SHALL have ports: src_data  in  8  payload byte; src_valid  in  1  byte present; src_ready  out  1  byte accepted when src_valid&&src_ready.
REQ-006 SHALL have ports: data_in  out  8  router input byte; pkt_valid  out  1  router packet-valid; busy  in  1  router busy; err  in  1  router parity error.
REQ-007 SHALL have ports: done  out  1  one-cycle pulse at packet end; pkt_err  out  1  sticky router error for the last packet, cleared on next accepted start.

Function
REQ-008 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK.
REQ-009 IDLE: start with cmd_addr!=2'b11 and cmd_len!=0 SHALL latch both, clear pkt_err, go LOAD; any other start SHALL pulse cmd_err next cycle and stay IDLE.
REQ-010 LOAD: src_ready=1; each accepted byte SHALL be written to buffer index cnt, cnt+1; the accept of byte cmd_len-1 SHALL move to HEADER next cycle; src_valid gaps SHALL stall without loss.
REQ-011 HEADER: data_in={len,addr}, pkt_valid=1; running parity SHALL be loaded with the header byte; advance to PAYLOAD at the edge where busy=0.
REQ-012 PAYLOAD: data_in=buffer[idx], pkt_valid=1; at each edge with busy=0, parity^=byte and idx+1; after byte len-1, go PARITY.
REQ-013 PARITY: data_in=accumulated parity, pkt_valid=0; advance to CHECK at edge with busy=0.
REQ-014 Whenever busy=1, data_in and pkt_valid SHALL hold their values unchanged and no state or index SHALL advance.
REQ-015 CHECK: lasts exactly 3 cycles; err=1 in any of them SHALL set pkt_err; on the last cycle assert done for one cycle and return to IDLE.
REQ-016 No payload byte SHALL be presented to the router before all cmd_len bytes are buffered (no gaps while pkt_valid=1).
REQ-017 Outside HEADER/PAYLOAD/PARITY, data_in SHALL be 8'h00 and pkt_valid 0.
REQ-018 start while not IDLE SHALL be ignored (cmd_ready=0, no cmd_err).
REQ-019 Maximum packet: cmd_len=63, header 8'hFC|addr; indices 6 bits, no wrap beyond len-1.

Reset
REQ-020 resetn=0 at a rising edge SHALL force IDLE from any state, including mid-packet.
REQ-021 Reset values: data_in=0, pkt_valid=0, src_ready=0, cmd_ready=1 after first non-reset cycle, cmd_err=0, done=0, pkt_err=0, counters and parity 0; buffer contents need not reset.

Configuration
REQ-022 Macro PKT_TX_ERR_INJECT_EN defined: SHALL add input inject_err (1 bit), latched at start accept; when latched, the PARITY byte SHALL be the accumulated parity inverted (~parity).
REQ-023 Macro undefined: no inject_err port; parity byte always correct.

Structure
REQ-024 Shared package pkt_tx_pkg SHALL hold the state enumeration, MAX_LEN=63, INVALID_ADDR=2'b11, CHECK_CYCLES=3.
REQ-025 Payload storage SHALL be sub-module pkt_tx_buf: 64x8 register array, one write port, one asynchronous read port.

Verification
REQ-026 addr=1, len=3, bytes 11,22,33, busy=0 -> data_in 0D,11,22,33 with pkt_valid 1,1,1,1 then 0 with data 0D^11^22^33=0D, done 3 cycles later, pkt_err=0.
REQ-027 Same packet, busy=1 for 2 cycles during byte 22 -> 22 held 3 cycles, sequence otherwise identical.
REQ-028 start with addr=3, len=4 -> cmd_err pulse, state IDLE; start with len=0 -> same.
REQ-029 len=63, addr=2, src_valid toggling every cycle -> 126 LOAD cycles, header FE, 63 payload bytes contiguous, correct parity.
REQ-030 resetn=0 during PAYLOAD byte 5 -> next cycle pkt_valid=0, data_in=00, cmd_ready=1.
REQ-031 PKT_TX_ERR_INJECT_EN, inject_err=1, router err driven high in CHECK cycle 2 -> parity byte inverted, pkt_err=1 until next start.
